matrix_fb_writer: RTL

//   Upstream write port of the panel frame RAM that the scan/refresh engine reads.

---
 rtl/matrix_pkg.sv | 44 ++++
 rtl/matrix_fb_writer_if.sv | 35 +++
 rtl/matrix_fb_addr_map.sv | 15 +
 rtl/matrix_fb_writer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared geometry, widths and FSM encoding for the panel frame-RAM writer.
// lane_merge places one RGB444 pixel into its lane of a 48-bit RAM word.
package matrix_pkg;

  localparam int COLS      = 128;
  localparam int SCAN_ROWS = 8;
  localparam int LANES     = 4;
  localparam int BPC       = 4;

  localparam int ADDR_W = 10;
  localparam int WORD_W = 48;
  localparam int X_W    = 7;
  localparam int Y_W    = 5;
  localparam int RGB_W  = 3 * BPC;
  localparam int LANE_W = $clog2(LANES);
  localparam int ROW_W  = $clog2(SCAN_ROWS);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * SCAN_ROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD1   = 3'd1,
    ST_RD2   = 3'd2,
    ST_WR    = 3'd3,
    ST_CLEAR = 3'd4
  } fb_state_t;

  // Replace exactly one 12-bit lane field; the other lanes pass through untouched.
  function automatic logic [WORD_W-1:0] lane_merge(
    input logic [WORD_W-1:0] word,
    input logic [LANE_W-1:0] lane,
    input logic [RGB_W-1:0]  rgb
  );
    logic [WORD_W-1:0] merged;
    merged = word;
    for (int l = 0; l < LANES; l++) begin
      if (lane == l[LANE_W-1:0]) begin
        merged[l*RGB_W +: RGB_W] = rgb;
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/matrix_fb_writer_if.sv
// Pixel/clear command port plus the write-side port of the dual-port frame RAM.
// A pixel transfers on a rising clk edge where pix_valid && pix_ready; pix_valid may
// be held across cycles and pix_x/pix_y/pix_rgb are sampled only on that edge.
interface matrix_fb_writer_if;
  import matrix_pkg::*;

  logic              pix_valid;
  logic              pix_ready;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;
  logic [RGB_W-1:0]  pix_rgb;

  logic              clr_start;
  logic [RGB_W-1:0]  clr_rgb;
  logic              busy;
  logic              clr_done;

  logic [ADDR_W-1:0] wr_mem_address;
  logic              wr_mem_write_en;
  logic [WORD_W-1:0] wr_mem_data;
  logic [WORD_W-1:0] wr_mem_rdata;

  // Writer side.
  modport slave (
    input  pix_valid, pix_x, pix_y, pix_rgb, clr_start, clr_rgb, wr_mem_rdata,
    output pix_ready, busy, clr_done, wr_mem_address, wr_mem_write_en, wr_mem_data
  );

  // Upstream producer and RAM side.
  modport master (
    output pix_valid, pix_x, pix_y, pix_rgb, clr_start, clr_rgb, wr_mem_rdata,
    input  pix_ready, busy, clr_done, wr_mem_address, wr_mem_write_en, wr_mem_data
  );

endinterface

// File: rtl/matrix_fb_addr_map.sv
// Pixel coordinate to RAM word address and lane: scan row selects the word row,
// the upper y bits pick which of the four panel rows sharing that word is hit.
module matrix_fb_addr_map
  import matrix_pkg::*;
(
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic [LANE_W-1:0] lane
);

  assign addr = {y[ROW_W-1:0], x};
  assign lane = y[Y_W-1:ROW_W];

endmodule

// File: rtl/matrix_fb_writer.sv
// Frame-RAM write port: per-pixel read-modify-write of 48-bit words and a
// whole-buffer fill. rst_n is a synchronous, active-high reset.
module matrix_fb_writer
  import matrix_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  matrix_fb_writer_if.slave  bus,
  output fb_state_t          dbg_state
);

  fb_state_t         state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [WORD_W-1:0] data_q, data_nxt;
  logic              we_q, we_nxt;
  logic              done_q, done_nxt;
  logic [LANE_W-1:0] lane_q, lane_nxt;
  logic [RGB_W-1:0]  rgb_q, rgb_nxt;

  logic [ADDR_W-1:0] map_addr;
  logic [LANE_W-1:0] map_lane;
  logic              idle;
  logic              accept;

  matrix_fb_addr_map u_addr_map (
    .x    (bus.pix_x),
    .y    (bus.pix_y),
    .addr (map_addr),
    .lane (map_lane)
  );

  assign idle = (state == ST_IDLE);

  // The clr_done cycle is IDLE but still refuses pixels so no accept lands on it.
  assign bus.pix_ready = idle && !rst_n && !bus.clr_start && !done_q;
  assign bus.busy      = !idle && !rst_n;
  assign accept        = bus.pix_valid && bus.pix_ready;

  assign bus.wr_mem_address  = addr_q;
  assign bus.wr_mem_write_en = we_q;
  assign bus.wr_mem_data     = data_q;
  assign bus.clr_done        = done_q;
  assign dbg_state           = state;

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    we_nxt    = 1'b0;
    done_nxt  = 1'b0;
    lane_nxt  = lane_q;
    rgb_nxt   = rgb_q;

    case (state)
      ST_IDLE: begin
        if (bus.clr_start) begin
          rgb_nxt   = bus.clr_rgb;
          addr_nxt  = '0;
          data_nxt  = {LANES{bus.clr_rgb}};
          we_nxt    = 1'b1;
          state_nxt = ST_CLEAR;
        end else if (accept) begin
          addr_nxt  = map_addr;
          lane_nxt  = map_lane;
          rgb_nxt   = bus.pix_rgb;
          state_nxt = ST_RD1;
        end
      end

      ST_RD1: begin
        state_nxt = ST_RD2;
      end

      // Read data for the latched address is valid in this cycle.
      ST_RD2: begin
        data_nxt  = lane_merge(bus.wr_mem_rdata, lane_q, rgb_q);
        we_nxt    = 1'b1;
        state_nxt = ST_WR;
      end

      ST_WR: begin
        state_nxt = ST_IDLE;
      end

      ST_CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          addr_nxt = addr_q + 1'b1;
          we_nxt   = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      lane_q <= '0;
      rgb_q  <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      data_q <= data_nxt;
      we_q   <= we_nxt;
      done_q <= done_nxt;
      lane_q <= lane_nxt;
      rgb_q  <= rgb_nxt;
    end
  end

endmodule
